// File: rtl/draw_rectangle_clip.sv
// draw_rectangle_clip: clipped filled/outline rectangle rasteriser.
// Emits one pixel per enabled cycle, row-major, no bubbles between rows.
module draw_rectangle_clip #(
   parameter int CORDW = 16
) (
   input  logic                    clk,
   input  logic                    reset_i,
   input  logic                    ena_draw_i,
   input  logic                    start_i,
   input  logic                    mode_i,
   input  logic signed [CORDW-1:0] x0_i,
   input  logic signed [CORDW-1:0] y0_i,
   input  logic signed [CORDW-1:0] x1_i,
   input  logic signed [CORDW-1:0] y1_i,
   input  logic signed [CORDW-1:0] clip_x0_i,
   input  logic signed [CORDW-1:0] clip_y0_i,
   input  logic signed [CORDW-1:0] clip_x1_i,
   input  logic signed [CORDW-1:0] clip_y1_i,
   output logic signed [CORDW-1:0] x_o,
   output logic signed [CORDW-1:0] y_o,
   output logic                    drawing_o,
   output logic                    busy_o,
   output logic                    done_o
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_INIT,
      S_EMIT,
      S_DONE
   } state_t;

   state_t state_q, state_d;

   logic signed [CORDW-1:0] xa_q, xb_q, ya_q, yb_q;
   logic signed [CORDW-1:0] cx0_q, cy0_q, cx1_q, cy1_q;
   logic signed [CORDW-1:0] x_q, y_q, x_d, y_d;
   logic                    mode_q;

   logic signed [CORDW-1:0] cxl, cxr, cyt, cyb;
   logic signed [CORDW-1:0] in_x, row_r, rs_x, rs_y;
   logic                    empty, lvis, rvis;
   logic                    cur_edge, in_ok, row_edge, rs_ok;

   // Clipped bounds and visibility of the vertical outline edges
   assign cxl   = (xa_q > cx0_q) ? xa_q : cx0_q;
   assign cxr   = (xb_q < cx1_q) ? xb_q : cx1_q;
   assign cyt   = (ya_q > cy0_q) ? ya_q : cy0_q;
   assign cyb   = (yb_q < cy1_q) ? yb_q : cy1_q;
   assign empty = (cxl > cxr) || (cyt > cyb);
   assign lvis  = (xa_q >= cx0_q) && (xa_q <= cx1_q);
   assign rvis  = (xb_q != xa_q) && (xb_q >= cx0_q) && (xb_q <= cx1_q);

   // Next pixel within the current row (edge rows span, interior rows jump)
   assign cur_edge = !mode_q || (y_q == ya_q) || (y_q == yb_q);
   assign in_ok    = cur_edge ? (x_q < cxr) : ((x_q == xa_q) && rvis);
   assign in_x     = cur_edge ? (x_q + CORDW'(1)) : xb_q;

   // Candidate next row; only used when it does not pass cyb
   assign row_r    = (state_q == S_INIT) ? cyt : (y_q + CORDW'(1));
   assign row_edge = !mode_q || (row_r == ya_q) || (row_r == yb_q);

   // First pixel of the next non-empty row; empty interior rows skip to yb
   always_comb begin
      rs_ok = 1'b0;
      rs_x  = cxl;
      rs_y  = row_r;
      if (row_edge) begin
         rs_ok = 1'b1;
      end else if (lvis || rvis) begin
         rs_ok = 1'b1;
         rs_x  = lvis ? xa_q : xb_q;
      end else if (yb_q <= cyb) begin
         rs_ok = 1'b1;
         rs_y  = yb_q;
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset_i) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   // Next-state and next-pixel logic
   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      unique case (state_q)
         S_IDLE: begin
            if (start_i) state_d = S_INIT;
         end
         S_INIT: begin
            if (empty || !rs_ok) begin
               state_d = S_DONE;
            end else begin
               state_d = S_EMIT;
               x_d     = rs_x;
               y_d     = rs_y;
            end
         end
         S_EMIT: begin
            if (ena_draw_i) begin
               if (in_ok) begin
                  x_d = in_x;
               end else if ((y_q < cyb) && rs_ok) begin
                  x_d = rs_x;
                  y_d = rs_y;
               end else begin
                  state_d = S_DONE;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Pixel position and latched shape/clip parameters
   always_ff @(posedge clk) begin
      if (reset_i) begin
         x_q    <= '0;
         y_q    <= '0;
         xa_q   <= '0;
         xb_q   <= '0;
         ya_q   <= '0;
         yb_q   <= '0;
         cx0_q  <= '0;
         cy0_q  <= '0;
         cx1_q  <= '0;
         cy1_q  <= '0;
         mode_q <= 1'b0;
      end else begin
         x_q <= x_d;
         y_q <= y_d;
         if (state_q == S_IDLE && start_i) begin
            xa_q   <= (x0_i < x1_i) ? x0_i : x1_i;
            xb_q   <= (x0_i < x1_i) ? x1_i : x0_i;
            ya_q   <= (y0_i < y1_i) ? y0_i : y1_i;
            yb_q   <= (y0_i < y1_i) ? y1_i : y0_i;
            cx0_q  <= clip_x0_i;
            cy0_q  <= clip_y0_i;
            cx1_q  <= clip_x1_i;
            cy1_q  <= clip_y1_i;
            mode_q <= mode_i;
         end
      end
   end

   // Outputs decoded from state
   always_comb begin
      x_o       = x_q;
      y_o       = y_q;
      drawing_o = (state_q == S_EMIT);
      busy_o    = (state_q == S_INIT) || (state_q == S_EMIT);
      done_o    = (state_q == S_DONE);
   end

endmodule

// File: tb/tb_draw_rectangle_clip.sv
// tb_draw_rectangle_clip: directed and random rectangles against a
// per-pixel set-membership model of the clipped rectangle.
module tb_draw_rectangle_clip;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic               reset_i, ena_draw_i, start_i, mode_i;
   logic signed [15:0] x0_i, y0_i, x1_i, y1_i;
   logic signed [15:0] clip_x0_i, clip_y0_i, clip_x1_i, clip_y1_i;
   logic signed [15:0] x_o, y_o;
   logic               drawing_o, busy_o, done_o;

   draw_rectangle_clip #(.CORDW(16)) dut (
      .clk(clk), .reset_i(reset_i), .ena_draw_i(ena_draw_i),
      .start_i(start_i), .mode_i(mode_i),
      .x0_i(x0_i), .y0_i(y0_i), .x1_i(x1_i), .y1_i(y1_i),
      .clip_x0_i(clip_x0_i), .clip_y0_i(clip_y0_i),
      .clip_x1_i(clip_x1_i), .clip_y1_i(clip_y1_i),
      .x_o(x_o), .y_o(y_o), .drawing_o(drawing_o),
      .busy_o(busy_o), .done_o(done_o)
   );

   int total = 0;
   int bad   = 0;
   int qx[$];
   int qy[$];

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Model: a pixel is drawn iff it lies inside rectangle and clip window,
   // and (fill mode, or it lies on one of the four rectangle sides).
   task automatic model(int x0, int y0, int x1, int y1, bit m,
                        int cx0, int cy0, int cx1, int cy1);
      int xa, xb, ya, yb;
      xa = (x0 < x1) ? x0 : x1;
      xb = (x0 < x1) ? x1 : x0;
      ya = (y0 < y1) ? y0 : y1;
      yb = (y0 < y1) ? y1 : y0;
      qx.delete();
      qy.delete();
      for (int y = ya; y <= yb; y++)
         for (int x = xa; x <= xb; x++)
            if (x >= cx0 && x <= cx1 && y >= cy0 && y <= cy1 &&
                (!m || y == ya || y == yb || x == xa || x == xb)) begin
               qx.push_back(x);
               qy.push_back(y);
            end
   endtask

   // smode: 0 ena always high, 1 random ena + ignored starts, 2 ena low
   // for the first three emit cycles. exp_done < 0 means derive it.
   task automatic run(int x0, int y0, int x1, int y1, bit m,
                      int cx0, int cy0, int cx1, int cy1,
                      int smode, int exp_done);
      int n, idx, cyc, stalls, ecyc;
      bit got_done, ena;
      model(x0, y0, x1, y1, m, cx0, cy0, cx1, cy1);
      n = qx.size();
      @(negedge clk);
      x0_i = 16'(x0); y0_i = 16'(y0);
      x1_i = 16'(x1); y1_i = 16'(y1);
      mode_i = m;
      clip_x0_i = 16'(cx0); clip_y0_i = 16'(cy0);
      clip_x1_i = 16'(cx1); clip_y1_i = 16'(cy1);
      start_i = 1'b1;
      ena_draw_i = (smode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      cyc = 1;
      chk("busy_init", 32'(busy_o), 32'd1);
      chk("draw_init", 32'(drawing_o), 32'd0);
      idx = 0; stalls = 0; ecyc = 0; got_done = 0;
      while (!got_done && cyc < 5000) begin
         @(negedge clk);
         cyc++;
         if (done_o) begin
            got_done = 1;
            start_i = 1'b0;
         end else if (drawing_o) begin
            if (idx < n)
               chk("pix", {x_o, y_o}, {16'(qx[idx]), 16'(qy[idx])});
            else
               chk("extra_pix", {x_o, y_o}, 32'hffffffff);
            if (smode == 1)      ena = ($urandom_range(0, 3) != 0);
            else if (smode == 2) ena = (ecyc >= 3);
            else                 ena = 1'b1;
            ena_draw_i = ena;
            ecyc++;
            if (ena) idx++;
            else     stalls++;
            if (smode == 1 && $urandom_range(0, 7) == 0) begin
               start_i = 1'b1;
               x0_i = 16'($urandom_range(0, 100));
               mode_i = ~mode_i;
            end else begin
               start_i = 1'b0;
            end
         end
      end
      chk("done_seen", 32'(got_done), 32'd1);
      if (exp_done < 0) chk("done_cyc", 32'(cyc), 32'(n + 2 + stalls));
      else              chk("done_cyc", 32'(cyc), 32'(exp_done));
      chk("npix", 32'(idx), 32'(n));
      chk("busy_done", 32'(busy_o), 32'd0);
      chk("draw_done", 32'(drawing_o), 32'd0);
      start_i = 1'b0;
      ena_draw_i = 1'b1;
      @(negedge clk);
      chk("done_pulse", 32'(done_o), 32'd0);
   endtask

   int rx0, ry0, rx1, ry1, c0, c1, c2, c3;

   initial begin
      reset_i = 1'b1; ena_draw_i = 1'b1; start_i = 1'b0; mode_i = 1'b0;
      x0_i = '0; y0_i = '0; x1_i = '0; y1_i = '0;
      clip_x0_i = '0; clip_y0_i = '0; clip_x1_i = '0; clip_y1_i = '0;
      repeat (3) @(negedge clk);
      chk("rst_xy", {x_o, y_o}, 32'd0);
      chk("rst_flags", {29'd0, drawing_o, busy_o, done_o}, 32'd0);
      reset_i = 1'b0;

      run(4, 5, 2, 3, 0, 0, 0, 639, 479, 0, 11);
      run(0, 0, 3, 2, 1, 0, 0, 639, 479, 0, 12);
      run(-2, -2, 1, 1, 0, 0, 0, 639, 479, 0, 6);
      run(-2, -2, 1, 1, 1, 0, 0, 639, 479, 0, 5);
      run(700, 10, 710, 20, 0, 0, 0, 639, 479, 0, 2);
      run(0, 0, 1, 0, 0, 0, 0, 639, 479, 2, 7);
      run(3, 1, 3, 6, 1, 0, 0, 639, 479, 0, -1);
      run(1, 4, 9, 4, 1, 0, 0, 639, 479, 0, -1);
      run(0, 0, 9, 9, 1, 3, 3, 6, 6, 0, 2);
      run(0, 0, 9, 9, 1, 3, 0, 6, 9, 0, -1);
      run(32760, -32768, 32767, -32764, 1,
          32762, -32768, 32767, 32767, 1, -1);

      // Reset mid-draw, then restart cleanly
      @(negedge clk);
      x0_i = 16'(4); y0_i = 16'(5); x1_i = 16'(2); y1_i = 16'(3);
      mode_i = 1'b0;
      clip_x0_i = '0; clip_y0_i = '0;
      clip_x1_i = 16'(639); clip_y1_i = 16'(479);
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      repeat (4) @(negedge clk);
      chk("pre_rst_pix", {x_o, y_o}, {16'(2), 16'(4)});
      reset_i = 1'b1;
      @(negedge clk);
      reset_i = 1'b0;
      chk("mid_rst_xy", {x_o, y_o}, 32'd0);
      chk("mid_rst_flags", {29'd0, drawing_o, busy_o, done_o}, 32'd0);

      // Reset beats a simultaneous start
      reset_i = 1'b1;
      start_i = 1'b1;
      @(negedge clk);
      reset_i = 1'b0;
      start_i = 1'b0;
      chk("rst_vs_start", 32'(busy_o), 32'd0);
      @(negedge clk);
      chk("rst_vs_start2", 32'(busy_o), 32'd0);
      run(4, 5, 2, 3, 0, 0, 0, 639, 479, 0, 11);

      for (int i = 0; i < 40; i++) begin
         rx0 = int'($urandom_range(0, 32)) - 8;
         ry0 = int'($urandom_range(0, 32)) - 8;
         rx1 = int'($urandom_range(0, 32)) - 8;
         ry1 = int'($urandom_range(0, 32)) - 8;
         if ($urandom_range(0, 3) == 0) begin
            c0 = 0; c1 = 0; c2 = 639; c3 = 479;
         end else begin
            c0 = int'($urandom_range(0, 24)) - 8;
            c1 = int'($urandom_range(0, 24)) - 8;
            c2 = c0 + int'($urandom_range(0, 30)) - 4;
            c3 = c1 + int'($urandom_range(0, 30)) - 4;
         end
         run(rx0, ry0, rx1, ry1, 1'($urandom_range(0, 1)),
             c0, c1, c2, c3, int'($urandom_range(0, 1)), -1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
